// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer for the instruction-fetch stage. Holds the current
// fetch address and advances it by INSTR_BYTES for every accepted fetch.
//
// Redirect priority in RUN, highest first:
//   trap, then branch/jump, then halt, then sequential advance.
// Every redirect produces a one-cycle flush pulse that lines up with the new PC.
// A HALT state supports WFI-style idling. In HALT only a trap or a resume
// request leaves the state.
//
// Parameters:
//   XLEN          address width in bits
//   RESET_VECTOR  PC loaded on reset (must be INSTR_BYTES-aligned)
//   INSTR_BYTES   sequential increment, 2 or 4
//
// Ports:
//   clock          in   single clock, rising-edge
//   reset_n        in   synchronous active-low reset
//   fetch_ready    in   instruction memory accepts pc_out this cycle
//   stall          in   hazard hold; blocks sequential advance only
//   branch_taken   in   branch/jump redirect request
//   branch_target  in   redirect address (low alignment bits cleared)
//   trap_take      in   exception/interrupt redirect request
//   trap_vector    in   trap handler address (low alignment bits cleared)
//   halt_req       in   enter HALT
//   resume         in   leave HALT
//   pc_out         out  current fetch address (registered)
//   pc_next        out  value pc_out takes at the next edge (combinational)
//   fetch_valid    out  pc_out is a valid fetch request (registered)
//   flush_out      out  one-cycle pulse with the first redirected PC
//   halted         out  high while in HALT
//   misaligned_out out  only with PC_MISALIGN_CHECK_EN; flags a misaligned
//                       branch target that was turned into a trap redirect
//
// Optional feature macro: PC_MISALIGN_CHECK_EN
//   When it is defined, a branch target with nonzero low alignment bits goes
//   to trap_vector and raises misaligned_out for one cycle. When it is not
//   defined, the low bits are cleared without any indication.
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INSTR_BYTES  = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            trap_take,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_next,
    output logic            fetch_valid,
    output logic            flush_out,
    output logic            halted
`ifdef PC_MISALIGN_CHECK_EN
    ,
    output logic            misaligned_out
`endif
);

    localparam int              ALIGN_BITS = (INSTR_BYTES == 2) ? 1 : 2;
    localparam logic [XLEN-1:0] LOW_MASK   = XLEN'((1 << ALIGN_BITS) - 1);
    localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            flush_q, flush_d;
    logic            halted_q, halted_d;
`ifdef PC_MISALIGN_CHECK_EN
    logic            misaligned_q, misaligned_d;
    logic            target_misaligned;
`endif

    // Clears the low alignment bits of an address.
    function automatic logic [XLEN-1:0] align_addr(input logic [XLEN-1:0] addr);
        return addr & ~LOW_MASK;
    endfunction

    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] branch_pc;

    assign trap_pc   = align_addr(trap_vector);
    assign branch_pc = align_addr(branch_target);
`ifdef PC_MISALIGN_CHECK_EN
    assign target_misaligned = |(branch_target & LOW_MASK);
`endif

    // Next-state logic and redirect priority
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
        misaligned_d = 1'b0;
`endif

        case (state_q)
            // BOOT holds the reset PC for exactly one cycle and ignores all
            // requests, so memory sees a stable address before fetching starts.
            ST_BOOT: begin
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (trap_take) begin
                    pc_d    = trap_pc;
                    flush_d = 1'b1;
                end else if (branch_taken) begin
                    flush_d = 1'b1;
`ifdef PC_MISALIGN_CHECK_EN
                    if (target_misaligned) begin
                        pc_d         = trap_pc;
                        misaligned_d = 1'b1;
                    end else begin
                        pc_d = branch_pc;
                    end
`else
                    pc_d = branch_pc;
`endif
                end else if (halt_req) begin
                    // Halt sits below both redirects. If a redirect happens in
                    // the same cycle, the halt request is dropped and must be
                    // asserted again.
                    state_d = ST_HALT;
                end else if (fetch_ready && !stall) begin
                    // Wraps modulo 2^XLEN by construction.
                    pc_d = pc_q + STEP;
                end
            end

            ST_HALT: begin
                // Branches cannot wake the core. Only a trap or resume can.
                if (trap_take) begin
                    pc_d    = trap_pc;
                    flush_d = 1'b1;
                    state_d = ST_RUN;
                end else if (resume) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // Status outputs are registered images of the state being entered,
        // so they change on the same edge as the state.
        fetch_valid_d = (state_d == ST_RUN);
        halted_d      = (state_d == ST_HALT);
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            halted_q      <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
            misaligned_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            halted_q      <= halted_d;
`ifdef PC_MISALIGN_CHECK_EN
            misaligned_q  <= misaligned_d;
`endif
        end
    end

    assign pc_out      = pc_q;
    assign pc_next     = pc_d;
    assign fetch_valid = fetch_valid_q;
    assign flush_out   = flush_q;
    assign halted      = halted_q;
`ifdef PC_MISALIGN_CHECK_EN
    assign misaligned_out = misaligned_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer. Directed scenarios plus randomized traffic are
// checked against a behavioural model of the fetch PC.
module tb_pc_sequencer;

    localparam int          XLEN = 64;
    localparam logic [63:0] RV   = 64'h1000;
    localparam logic [63:0] AMSK = ~64'h3;
`ifdef PC_MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n, fetch_ready, stall, branch_taken, trap_take, halt_req, resume;
    logic [63:0] branch_target, trap_vector;
    logic [63:0] pc_out, pc_next;
    logic        fetch_valid, flush_out, halted;
`ifdef PC_MISALIGN_CHECK_EN
    logic        misaligned_out;
`endif

    always #5 clock = ~clock;

    pc_sequencer #(
        .XLEN(XLEN), .RESET_VECTOR(RV), .INSTR_BYTES(4)
    ) dut (
        .clock(clock), .reset_n(reset_n), .fetch_ready(fetch_ready), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .trap_take(trap_take), .trap_vector(trap_vector),
        .halt_req(halt_req), .resume(resume),
        .pc_out(pc_out), .pc_next(pc_next), .fetch_valid(fetch_valid),
        .flush_out(flush_out), .halted(halted)
`ifdef PC_MISALIGN_CHECK_EN
        , .misaligned_out(misaligned_out)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural model: the PC plus "still booting" / "sleeping" flags and
    // the one-cycle flags raised by a redirect.
    logic [63:0] m_pc;
    bit m_boot, m_halt, m_flush, m_mis;

    task automatic predict(output logic [63:0] n_pc, output bit n_boot, output bit n_halt,
                           output bit n_flush, output bit n_mis);
        n_pc = m_pc; n_boot = m_boot; n_halt = m_halt; n_flush = 0; n_mis = 0;
        if (!reset_n) begin
            n_pc = RV; n_boot = 1; n_halt = 0;
        end else if (m_boot) begin
            n_boot = 0;
        end else if (m_halt) begin
            if (trap_take) begin
                n_pc = trap_vector & AMSK; n_halt = 0; n_flush = 1;
            end else if (resume) begin
                n_halt = 0;
            end
        end else if (trap_take) begin
            n_pc = trap_vector & AMSK; n_flush = 1;
        end else if (branch_taken) begin
            n_flush = 1;
            if (CHK && branch_target[1:0] != 2'b00) begin
                n_pc = trap_vector & AMSK; n_mis = 1;
            end else begin
                n_pc = branch_target & AMSK;
            end
        end else if (halt_req) begin
            n_halt = 1;
        end else if (fetch_ready && !stall) begin
            n_pc = m_pc + 64'd4;
        end
    endtask

    // Runs one clock with the inputs currently driven, checking pc_next before
    // the edge and the registered outputs just after it.
    task automatic cycle();
        logic [63:0] n_pc;
        bit n_boot, n_halt, n_flush, n_mis;
        #1;
        predict(n_pc, n_boot, n_halt, n_flush, n_mis);
        if (reset_n) check("pc_next", pc_next, n_pc);
        @(posedge clock);
        #1;
        m_pc = n_pc; m_boot = n_boot; m_halt = n_halt; m_flush = n_flush; m_mis = n_mis;
        check("pc_out", pc_out, m_pc);
        check("fetch_valid", 64'(fetch_valid), 64'(!m_boot && !m_halt));
        check("flush_out", 64'(flush_out), 64'(m_flush));
        check("halted", 64'(halted), 64'(m_halt));
`ifdef PC_MISALIGN_CHECK_EN
        check("misaligned_out", 64'(misaligned_out), 64'(m_mis));
`endif
    endtask

    task automatic idle();
        reset_n = 1; fetch_ready = 1; stall = 0; branch_taken = 0; trap_take = 0;
        halt_req = 0; resume = 0;
    endtask

    task automatic jump(input logic [63:0] t);
        idle(); branch_taken = 1; branch_target = t; cycle(); idle();
    endtask

    initial begin
        m_pc = '0; m_boot = 1; m_halt = 0; m_flush = 0; m_mis = 0;
        idle(); branch_target = '0; trap_vector = 64'h80;

        // Reset and boot sequence
        reset_n = 0; cycle(); cycle();
        check("rst_pc", pc_out, RV);
        check("rst_valid", 64'(fetch_valid), 64'd0);
        check("rst_flush", 64'(flush_out), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        idle();
        cycle(); check("boot_pc", pc_out, 64'h1000); check("boot_valid", 64'(fetch_valid), 64'd1);
        cycle(); check("seq1", pc_out, 64'h1004);
        cycle(); check("seq2", pc_out, 64'h1008);
        cycle(); check("seq3", pc_out, 64'h100C);

        // Stall holds; a redirect during the stall still takes effect
        jump(64'h2000);
        stall = 1;
        for (int i = 0; i < 3; i++) begin cycle(); check("stall_hold", pc_out, 64'h2000); end
        branch_taken = 1; branch_target = 64'h3000; cycle();
        check("stall_br_pc", pc_out, 64'h3000); check("stall_br_flush", 64'(flush_out), 64'd1);
        idle();

        // Trap beats branch in the same cycle
        trap_take = 1; trap_vector = 64'h80; branch_taken = 1; branch_target = 64'h4000; cycle();
        check("trap_win_pc", pc_out, 64'h80); check("trap_win_flush", 64'(flush_out), 64'd1);
        idle(); cycle();
        check("flush_single", 64'(flush_out), 64'd0); check("after_trap", pc_out, 64'h84);

        // HALT, branch ignored, resume, then wake by trap
        jump(64'h500);
        halt_req = 1; cycle();
        check("halt_h", 64'(halted), 64'd1); check("halt_v", 64'(fetch_valid), 64'd0);
        check("halt_pc", pc_out, 64'h500);
        idle(); branch_taken = 1; branch_target = 64'h4000; cycle();
        check("halt_br_ign", pc_out, 64'h500); check("halt_br_flush", 64'(flush_out), 64'd0);
        idle(); resume = 1; cycle();
        check("resume_v", 64'(fetch_valid), 64'd1); check("resume_pc", pc_out, 64'h500);
        check("resume_flush", 64'(flush_out), 64'd0);
        idle(); cycle(); check("resume_seq", pc_out, 64'h504);
        halt_req = 1; cycle(); idle();
        trap_take = 1; trap_vector = 64'h80; cycle();
        check("halt_trap_pc", pc_out, 64'h80); check("halt_trap_flush", 64'(flush_out), 64'd1);
        check("halt_trap_run", 64'(fetch_valid), 64'd1);
        idle();

        // Wrap at the top of the address space
        jump(64'hFFFF_FFFF_FFFF_FFFC);
        cycle(); check("wrap", pc_out, 64'h0);

        // Reset wins over a redirect in the same cycle
        trap_take = 1; branch_taken = 1; branch_target = 64'h7000; reset_n = 0; cycle();
        check("rst_redir_pc", pc_out, RV); check("rst_redir_flush", 64'(flush_out), 64'd0);
        idle(); cycle();

        // Misaligned branch target
        trap_vector = 64'h80;
        branch_taken = 1; branch_target = 64'h1002; cycle();
        check("misalign_pc", pc_out, CHK ? 64'h80 : 64'h1000);
`ifdef PC_MISALIGN_CHECK_EN
        check("misalign_flag", 64'(misaligned_out), 64'd1);
        idle(); cycle();
        check("misalign_clr", 64'(misaligned_out), 64'd0);
`endif
        idle();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset_n       = ($urandom_range(0, 199) != 0);
            fetch_ready   = ($urandom_range(0, 9) < 8);
            stall         = ($urandom_range(0, 3) == 0);
            trap_take     = ($urandom_range(0, 19) == 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            halt_req      = ($urandom_range(0, 19) == 0);
            resume        = ($urandom_range(0, 3) == 0);
            branch_target = {$urandom, $urandom};
            trap_vector   = {$urandom, $urandom};
            if ($urandom_range(0, 49) == 0) branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
